// File: rtl/hex_display_arbiter_if.sv
// Request/display bundle between the control FSMs (master) and the display arbiter (slave).
// Message digit k of requester r sits at [(r*8+k)*GLYPH_W +: GLYPH_W]; digit 7 is leftmost.
interface hex_display_arbiter_if #(
    parameter int N_REQ   = 3,
    parameter int GLYPH_W = 5
);
    logic [N_REQ-1:0]           i_req_valid;
    logic [N_REQ-1:0]           o_req_ready;
    logic [N_REQ*8*GLYPH_W-1:0] i_req_msg;
    logic [N_REQ-1:0]           i_req_blink;
    logic [8*GLYPH_W-1:0]       i_base_msg;
    logic [8*GLYPH_W-1:0]       o_glyph;
    logic [1:0]                 o_src;
    logic                       o_busy;

    modport master (
        output i_req_valid, i_req_msg, i_req_blink, i_base_msg,
        input  o_req_ready, o_glyph, o_src, o_busy
    );

    modport slave (
        input  i_req_valid, i_req_msg, i_req_blink, i_base_msg,
        output o_req_ready, o_glyph, o_src, o_busy
    );
endinterface

// File: rtl/hex_display_arbiter.sv
// Shares the 8-digit display between prioritised message requesters; each accepted
// message is held for HOLD_CYCLES (optionally blinking), otherwise the base word is shown.
module hex_display_arbiter #(
    parameter int N_REQ        = 3,
    parameter int GLYPH_W      = 5,
    parameter int HOLD_CYCLES  = 24000000,
    parameter int BLINK_CYCLES = 3000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    hex_display_arbiter_if.slave  bus
);
    localparam int MSG_W   = 8 * GLYPH_W;
    localparam int HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [1:0]       SRC_BASE = 2'd3;
    localparam logic [MSG_W-1:0] ALL_DARK = '1;   // glyph 31 in every digit

    typedef enum logic {IDLE, SHOW} state_t;

    state_t               state_reg, state_next;
    logic [1:0]           cur_reg, cur_next;
    logic [HOLD_W-1:0]    hold_reg, hold_next;
    logic [BLINK_W-1:0]   blink_cnt_reg, blink_cnt_next;
    logic                 phase_reg, phase_next;
    logic                 blink_en_reg, blink_en_next;
    logic [MSG_W-1:0]     msg_reg, msg_next;
    logic [MSG_W-1:0]     glyph_reg, glyph_next;

    logic [MSG_W-1:0]     req_msg_arr [N_REQ];
    logic [1:0]           win_idx;
    logic                 any_valid;
    logic                 hold_last;
    logic                 blink_last;
    logic                 grant_ok;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_msg_arr[gi]     = bus.i_req_msg[gi*MSG_W +: MSG_W];
            assign bus.o_req_ready[gi] = grant_ok && (win_idx == 2'(gi));
        end
    endgenerate

    // Lowest valid index wins.
    always_comb begin
        win_idx   = '0;
        any_valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.i_req_valid[i]) begin
                win_idx   = 2'(i);
                any_valid = 1'b1;
            end
        end
    end

    assign hold_last  = (hold_reg == HOLD_W'(HOLD_CYCLES - 1));
    assign blink_last = (blink_cnt_reg == BLINK_W'(BLINK_CYCLES - 1));
    // Ready implies the winner's valid is high, so a grant is always a transfer.
    assign grant_ok   = any_valid && !i_rst &&
                        (state_reg == IDLE || win_idx <= cur_reg || hold_last);

    always_comb begin
        state_next     = state_reg;
        cur_next       = cur_reg;
        hold_next      = hold_reg;
        blink_cnt_next = blink_cnt_reg;
        phase_next     = phase_reg;
        blink_en_next  = blink_en_reg;
        msg_next       = msg_reg;
        glyph_next     = bus.i_base_msg;

        if (state_reg == SHOW) begin
            glyph_next = phase_reg ? ALL_DARK : msg_reg;
        end

        if (grant_ok) begin
            state_next     = SHOW;
            cur_next       = win_idx;
            msg_next       = req_msg_arr[win_idx];
            blink_en_next  = bus.i_req_blink[win_idx];
            hold_next      = '0;
            blink_cnt_next = '0;
            phase_next     = 1'b0;
        end else if (state_reg == SHOW) begin
            if (hold_last) begin
                state_next     = IDLE;
                hold_next      = '0;
                blink_cnt_next = '0;
                phase_next     = 1'b0;
            end else begin
                hold_next = hold_reg + HOLD_W'(1);
                if (blink_en_reg) begin
                    if (blink_last) begin
                        blink_cnt_next = '0;
                        phase_next     = ~phase_reg;
                    end else begin
                        blink_cnt_next = blink_cnt_reg + BLINK_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            cur_reg       <= '0;
            hold_reg      <= '0;
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            blink_en_reg  <= 1'b0;
            msg_reg       <= ALL_DARK;
            glyph_reg     <= ALL_DARK;
        end else begin
            state_reg     <= state_next;
            cur_reg       <= cur_next;
            hold_reg      <= hold_next;
            blink_cnt_reg <= blink_cnt_next;
            phase_reg     <= phase_next;
            blink_en_reg  <= blink_en_next;
            msg_reg       <= msg_next;
            glyph_reg     <= glyph_next;
        end
    end

    assign bus.o_glyph = glyph_reg;
    assign bus.o_src   = (state_reg == SHOW) ? cur_reg : SRC_BASE;
    assign bus.o_busy  = (state_reg == SHOW);
endmodule
